aes_192_dec: RTL and testbench
==============================

Name: aes_192_dec

Overview:
- Iterative AES-192 inverse cipher (FIPS-197 InvCipher, Nk=6, Nr=12).
- Companion to the AES-192 encryption pipeline: same start-edge / out_valid handshake and the same key and state byte ordering.
- Recovers plaintext from ciphertext produced by the encryptor with the same 192-bit key.
- Expands the key on-chip once per operation, then runs one inverse round per clock.

Parameters:
- None. Nk=6, Nr=12 and the Rcon table are fixed constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_i  in  1  synchronous active-high reset
- start  in  1  operation request; only its rising edge (start & ~start_r) is acted on
- state  in  128  ciphertext; [127:120] is byte 0 (FIPS column-major order)
- key  in  192  cipher key; [191:160] is w[0], [31:0] is w[5]
- out  out  128  plaintext, same byte order as state
- out_valid  out  1  high while out holds a finished result
- busy  out  1  high from capture until out_valid rises

Behaviour:
- Interface: one clock (clk); reset rst_i is synchronous and active-high.
- Reset values: out=0, out_valid=0, busy=0, FSM=IDLE, start_r=0, round counter=0. The key-word array is not reset.
- start_r registers start every cycle. start held high causes exactly one operation.
- FSM states: IDLE -> KEXP -> INIT -> ROUND -> DONE. DONE returns to IDLE only on reset, or goes to KEXP on a new start edge.
- Capture cycle (start edge sampled, from any state):
  - Latch state into ct_r and key into w[0..5].
  - Set widx=6, out_valid<=0, busy<=1, FSM<=KEXP.
- KEXP: one word per cycle, for widx = 6..51 (46 cycles):
  - w[i] = w[i-6] ^ t, where t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/6],24'h0} if i%6==0, else t = w[i-1].
  - Rcon = 01,02,04,08,10,20,40,80.
  - At widx==51 go to INIT.
- INIT (1 cycle): s <= ct_r ^ {w[48],w[49],w[50],w[51]}; set rnd=11.
- ROUND, one cycle per round:
  - For rnd = 11..1: s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[rnd]).
  - rnd=0: out <= InvSubBytes(InvShiftRows(s)) ^ rk[0]; out_valid<=1; busy<=0; FSM<=DONE.
  - rk[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- Latency: out_valid rises exactly 60 clock edges after the capture edge (46 KEXP + 1 INIT + 12 ROUND + 1 register).
- out and out_valid hold until the next start edge or reset.
- Start edge while busy: the current operation is abandoned and new inputs are captured. No out_valid pulse is produced for the abandoned operation.
- rst_i mid-operation: return to IDLE with the reset values above on the next edge. rst_i has priority over start.
- Inputs state and key are don't-care after the capture edge.
- Datapath: one combinational inverse-round unit and one forward S-box column (4 S-boxes) for key expansion.

Decomposition:
- Package aes_192_pkg:
  - Constants NK=6, NR=12, NWORDS=52.
  - RCON table.
  - Forward and inverse S-box functions.
  - GF(2^8) xtime and mul helpers (x9, xb, xd, xe).
  - FSM state enum.
- Sub-module aes_inv_round: combinational; inputs s, rk, last; output next state. The last flag skips InvMixColumns.
- The key-expansion step stays inline in the top module.

Test Plan:
- Reset: hold rst_i 3 cycles -> out=0, out_valid=0, busy=0. Keep start low 100 cycles -> out_valid stays 0.
- FIPS-197 C.2 vector: key=000102030405060708090a0b0c0d0e0f1011121314151617, state=dda97ca4864cdfe06eaf70a0ec0d7191, start pulse -> out=00112233445566778899aabbccddeeff, with out_valid rising exactly 60 edges after capture and busy high throughout.
- SP800-38A ECB-AES192 vector: key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, state=bd334f1d6e45f25ff712a214571fa5cc, start held high 80 cycles -> out=6bc1bee22e409f96e93d7e117393172a; only one operation runs.
- Restart: start the C.2 vector; at edge 20 drop start, then at edge 25 raise it with the SP800-38A inputs -> no valid for the first operation; out=6bc1bee2...172a valid 60 edges after the second capture.
- Mid-op reset: start the C.2 vector; assert rst_i at edge 30 for 1 cycle -> busy=0 and out_valid=0 from the next edge, and stays 0 for 100 cycles.
- Input isolation: after capture, drive state and key with random values every cycle -> result is identical to the C.2 expected plaintext.

Source files
------------

// File: rtl/aes_192_pkg.sv
// Shared constants, GF(2^8) helpers, S-boxes and FSM encoding for the
// iterative AES-192 inverse cipher.
package aes_192_pkg;

  localparam int NK     = 6;
  localparam int NR     = 12;
  localparam int NWORDS = 52;

  // Round constants for key-expansion words 6, 12, ..., 48.
  localparam logic [0:7][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08,
                                      8'h10, 8'h20, 8'h40, 8'h80};

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] a); return gf_mul(a, 8'h09); endfunction
  function automatic logic [7:0] xb(input logic [7:0] a); return gf_mul(a, 8'h0b); endfunction
  function automatic logic [7:0] xd(input logic [7:0] a); return gf_mul(a, 8'h0d); endfunction
  function automatic logic [7:0] xe(input logic [7:0] a); return gf_mul(a, 8'h0e); endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_192_pkg::*;
(
  input  logic [127:0] s,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next
);

  logic [7:0] ark [16];

  // Byte n = row + 4*col; inverse shift moves row r right by r columns.
  function automatic int src_idx(input int n);
    return (n % 4) + 4 * (((n / 4) - (n % 4)) & 3);
  endfunction

  // Substitution, row shift and key addition, then optional column mix.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    next = '0;
    for (int n = 0; n < 16; n++) begin
      ark[n] = inv_sbox(s[127 - 8*src_idx(n) -: 8]) ^ rk[127 - 8*n -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        next[127 - 32*c -: 32] = {ark[4*c], ark[4*c+1], ark[4*c+2], ark[4*c+3]};
      end else begin
        next[127 - 32*c -: 32] = {
          xe(ark[4*c]) ^ xb(ark[4*c+1]) ^ xd(ark[4*c+2]) ^ x9(ark[4*c+3]),
          x9(ark[4*c]) ^ xe(ark[4*c+1]) ^ xb(ark[4*c+2]) ^ xd(ark[4*c+3]),
          xd(ark[4*c]) ^ x9(ark[4*c+1]) ^ xe(ark[4*c+2]) ^ xb(ark[4*c+3]),
          xb(ark[4*c]) ^ xd(ark[4*c+1]) ^ x9(ark[4*c+2]) ^ xe(ark[4*c+3])};
      end
    end
  end

endmodule

// File: rtl/aes_192_dec.sv
// Iterative AES-192 decryptor: on-chip key expansion (one word per clock)
// followed by one inverse round per clock and a registered result.
module aes_192_dec
  import aes_192_pkg::*;
(
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [191:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  output logic         busy
);

  state_e        fsm_q, fsm_d;
  logic          start_r;
  logic          start_edge;
  logic [127:0]  ct_r;
  logic [127:0]  s_r;
  logic [5:0]    widx;
  logic [3:0]    rnd;
  logic          fin_pend;
  logic [31:0]   w [NWORDS];
  logic [31:0]   prev_w, temp_w, new_w;
  logic [5:0]    rk_base;
  logic [127:0]  round_key, round_out;

  assign start_edge = start & ~start_r;

  // Next key word from the two words it depends on.
  always_comb begin
    prev_w = w[widx - 6'd1];
    if (widx % 6'(NK) == 6'd0)
      temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^
               {RCON[3'((widx / 6'(NK)) - 6'd1)], 24'h0};
    else
      temp_w = prev_w;
    new_w = w[widx - 6'(NK)] ^ temp_w;
  end

  assign rk_base   = {rnd, 2'b00};
  assign round_key = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};

  aes_inv_round u_round (
    .s    (s_r),
    .rk   (round_key),
    .last (rnd == 4'd0),
    .next (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic; a start edge restarts from any state.
  always_comb begin
    fsm_d = fsm_q;
    if (start_edge) begin
      fsm_d = KEXP;
    end else begin
      unique case (fsm_q)
        KEXP:    if (widx == 6'(NWORDS - 1)) fsm_d = INIT;
        INIT:    fsm_d = ROUND;
        ROUND:   if (rnd == 4'd0) fsm_d = DONE;
        default: fsm_d = fsm_q;
      endcase
    end
  end

  // Key-word array: capture the cipher key, then append expanded words.
  always_ff @(posedge clk) begin
    // NOTE: the key array has no reset; every word is written before it is read.
    if (start_edge && !rst_i) begin
      for (int i = 0; i < NK; i++) w[i] <= key[191 - 32*i -: 32];
    end else if (fsm_q == KEXP) begin
      w[widx] <= new_w;
    end
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      start_r   <= 1'b0;
      ct_r      <= '0;
      s_r       <= '0;
      widx      <= '0;
      rnd       <= '0;
      fin_pend  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start_r <= start;
      if (start_edge) begin
        ct_r      <= state;
        widx      <= 6'(NK);
        fin_pend  <= 1'b0;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end else begin
        unique case (fsm_q)
          KEXP: widx <= widx + 6'd1;
          INIT: begin
            s_r <= ct_r ^ {w[48], w[49], w[50], w[51]};
            rnd <= 4'(NR - 1);
          end
          ROUND: begin
            s_r <= round_out;
            if (rnd == 4'd0) fin_pend <= 1'b1;
            else             rnd <= rnd - 4'd1;
          end
          DONE: if (fin_pend) begin
            out       <= s_r;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fin_pend  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_192_dec.sv
// Directed bench for aes_192_dec using published AES-192 vectors.
module tb_aes_192_dec;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start;
  logic [127:0] state;
  logic [191:0] key;
  logic [127:0] out;
  logic         out_valid;
  logic         busy;

  int passed = 0;
  int total  = 0;

  localparam logic [191:0] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C2_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] SP_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] SP_CT  = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;

  aes_192_dec dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .start     (start),
    .state     (state),
    .key       (key),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Called right after the capture edge; counts edges until out_valid.
  task automatic wait_valid(input bit scramble, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = busy;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (scramble) begin
        state = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic launch(input logic [127:0] ct, input logic [191:0] k);
    @(negedge clk);
    state = ct;
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit flag;

    rst_i = 1'b1;
    start = 1'b0;
    state = '0;
    key   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 128'h0);
    check("rst_valid", {127'h0, out_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    @(negedge clk);
    rst_i = 1'b0;
    flag = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid) flag = 1'b1;
    end
    check("idle_no_valid", {127'h0, flag}, 128'h0);

    // FIPS-197 C.2 with a one-cycle start pulse.
    launch(C2_CT, C2_KEY);
    start = 1'b0;
    wait_valid(1'b0, lat, busy_ok);
    check("c2_out", out, C2_PT);
    check("c2_latency", 128'(lat), 128'd60);
    check("c2_busy_held", {127'h0, busy_ok}, 128'h1);
    check("c2_busy_clear", {127'h0, busy}, 128'h0);

    // SP800-38A with start held high for 80 cycles: a single operation.
    repeat (3) @(posedge clk);
    launch(SP_CT, SP_KEY);
    wait_valid(1'b0, lat, busy_ok);
    check("sp_out", out, SP_PT);
    check("sp_latency", 128'(lat), 128'd60);
    flag = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
      if (!out_valid || busy || out !== SP_PT) flag = 1'b1;
    end
    check("sp_single_op", {127'h0, flag}, 128'h0);
    @(negedge clk);
    start = 1'b0;

    // Restart while busy: first operation is abandoned.
    repeat (3) @(posedge clk);
    launch(C2_CT, C2_KEY);
    flag = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (out_valid) flag = 1'b1;
      if (e == 20) start = 1'b0;
    end
    state = SP_CT;
    key   = SP_KEY;
    start = 1'b1;
    @(posedge clk); #1;
    if (out_valid) flag = 1'b1;
    start = 1'b0;
    wait_valid(1'b0, lat, busy_ok);
    check("rs_no_early_valid", {127'h0, flag}, 128'h0);
    check("rs_latency", 128'(lat), 128'd60);
    check("rs_out", out, SP_PT);

    // Reset in the middle of an operation.
    repeat (3) @(posedge clk);
    launch(C2_CT, C2_KEY);
    start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mr_busy", {127'h0, busy}, 128'h0);
    check("mr_valid", {127'h0, out_valid}, 128'h0);
    check("mr_out", out, 128'h0);
    flag = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid || busy) flag = 1'b1;
    end
    check("mr_stays_idle", {127'h0, flag}, 128'h0);

    // Inputs scrambled after capture must not disturb the result.
    launch(C2_CT, C2_KEY);
    start = 1'b0;
    wait_valid(1'b1, lat, busy_ok);
    check("iso_out", out, C2_PT);
    check("iso_latency", 128'(lat), 128'd60);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
